mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2, meaning extra cycles inserted between request acceptance and completion (legal range 0..15).
REQ-002 SHALL have parameter ADDR_W, default 9, meaning address width; storage depth SHALL be 2**ADDR_W words.
REQ-003 SHALL have parameter DATA_W, default 32, meaning word width.
REQ-004 Clock  input  1  single clock; all state changes on rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 Address  input  ADDR_W  word address from the requester's MAR.
REQ-007 Data_In  input  DATA_W  write data from the requester's MDR.
REQ-008 Read  input  1  read request level, held until Done seen.
REQ-009 Write  input  1  write request level, held until Done seen.
REQ-010 Data_Out  output  DATA_W  registered read data.
REQ-011 Done  output  1  registered completion flag, four-phase handshake.
REQ-012 Busy  output  1  high whenever state is not IDLE.
REQ-013 Error  output  1  registered flag: Read and Write both high in IDLE.

Function
REQ-014 SHALL implement states IDLE, WAIT, ACCESS, HOLD.
REQ-015 IDLE: exactly one of Read/Write high at an edge -> latch Address, Data_In, operation; go to WAIT with counter = WAIT_STATES, or directly to ACCESS if WAIT_STATES = 0.
REQ-016 IDLE: Read and Write both high -> Error = 1 next cycle, no latch, remain IDLE; Error = 0 in every other cycle.
REQ-017 WAIT: counter decrements by 1 each cycle; counter = 1 at an edge -> go to ACCESS.
REQ-018 WAIT: both Read and Write low at an edge -> abort to IDLE; no storage write; Done never asserted.
REQ-019 Address/Data_In changes after acceptance SHALL be ignored; latched values used.
REQ-020 ACCESS (one cycle): write -> latched data stored at latched address; read -> stored word loaded into Data_Out; Done = 1 from next cycle; go to HOLD.
REQ-021 HOLD: Done held 1 while Read or Write high; both low at an edge -> Done = 0 and IDLE next cycle.
REQ-022 Latency: request sampled at edge k -> Done high after edge k+WAIT_STATES+2 (WAIT_STATES = 0: after edge k+2).
REQ-023 Data_Out SHALL hold last read value across writes, aborts and errors until next read completion or reset.
REQ-024 Write-then-read to the same address SHALL return the new word (no stale-read hazard).
REQ-025 Next request SHALL NOT be accepted until IDLE is re-entered; minimum one IDLE cycle between transactions.
REQ-026 Storage SHALL initialise to all zeros at configuration; address wrap not applicable (full address space decoded).

Reset
REQ-027 Reset high at an edge -> state IDLE, Done = 0, Busy = 0, Error = 0, Data_Out = 0, counter = 0, regardless of current state.
REQ-028 Reset SHALL NOT alter storage contents; a write in WAIT at reset SHALL be discarded; a write in ACCESS at reset SHALL NOT be performed.
REQ-029 Reset SHALL dominate any simultaneous Read/Write.

Verification
REQ-030 WAIT_STATES=2: Write=1, Address=0x005, Data_In=0xDEADBEEF at edge 0 -> Busy next cycle, Done=1 after edge 4; drop Write -> Done=0, Busy=0 one cycle later.
REQ-031 After REQ-030, Read=1, Address=0x005 -> Data_Out=0xDEADBEEF with Done=1 after edge k+4; never-written 0x1FF reads 0x00000000.
REQ-032 Read=Write=1 in IDLE -> Error=1 each following cycle, Busy=0; storage and Data_Out unchanged.
REQ-033 Write 0x12345678 to 0x010, drop Write in WAIT -> IDLE, Done never 1; read 0x010 returns prior value 0x00000000.
REQ-034 Reset asserted in ACCESS of write 0xCAFEF00D to 0x020 -> all outputs 0 next cycle; read 0x020 returns 0x00000000.
REQ-035 WAIT_STATES=0: Read at edge k -> Done after edge k+2; Address changed at edge k+1 -> data from originally latched address.

Source files
------------

// File: rtl/mem_responder.sv
// Wait-state memory slave: accepts a held Read/Write level, inserts WAIT_STATES
// cycles, performs one access and holds Done until the request level drops.
module mem_responder #(
  parameter int WAIT_STATES = 2,
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Read,
  input  logic              Write,
  output logic [DATA_W-1:0] Data_Out,
  output logic              Done,
  output logic              Busy,
  output logic              Error
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_wr;

  // Storage comes up zeroed from configuration and is never touched by Reset.
  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

  assign Busy = (state != IDLE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      Data_Out <= '0;
    end else begin
      Error <= 1'b0;
      case (state)
        IDLE: begin
          if (Read && Write) begin
            Error <= 1'b1;
          end else if (Read || Write) begin
            lat_addr <= Address;
            lat_data <= Data_In;
            lat_wr   <= Write;
            if (WAIT_STATES == 0) begin
              state <= ACCESS;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          if (!Read && !Write) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == 4'd1) begin
            state <= ACCESS;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACCESS: begin
          if (!lat_wr) Data_Out <= mem[lat_addr];
          state <= HOLD;
        end
        HOLD: begin
          // Done rises on the first HOLD edge, giving WAIT_STATES+2 total latency.
          if (!Read && !Write) begin
            Done  <= 1'b0;
            state <= IDLE;
          end else begin
            Done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset && state == ACCESS && lat_wr) mem[lat_addr] <= lat_data;
  end

endmodule
